// File: rtl/frame_rx_oversampled.sv
// Oversampled serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Samples the synchronised line at mid-bit, checks parity and stop, and reports
// each completed frame with a one-cycle Ready strobe plus held status levels.
module frame_rx_oversampled #(
    parameter int unsigned BIT_TICKS  = 16,
    parameter int unsigned DATA_W     = 10,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              Rx,
    output logic [DATA_W-1:0] Frame,
    output logic              Valid,
    output logic              Ready,
    output logic              ParityErr,
    output logic              FrameErr,
    output logic              Busy
);

    localparam int unsigned TickW = $clog2(BIT_TICKS);
    localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TickW-1:0] TickHalf = TickW'(BIT_TICKS / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(BIT_TICKS - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [TickW-1:0]    tick_q, tick_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   frame_q, frame_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                rx_s;
    logic                parity_bad;

    assign rx_s = sync_q[1];

    // Received parity bit disagrees with the parity of the shifted-in data word.
    assign parity_bad = (^shift_q ^ PARITY_ODD) != par_q;

    // Two-flop synchroniser input; idles high so reset never looks like a start bit.
    always_comb begin
        sync_d = {sync_q[0], Rx};
    end

    // Receive FSM: mid-bit sampling, shift-in, and end-of-frame status update.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + TickW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        frame_d = frame_q;
        valid_d = valid_q;
        ready_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;

        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick_q == TickHalf) begin
                    tick_d = '0;
                    if (rx_s) begin
                        // Line went back high before mid-start: glitch, drop silently.
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
            end
            StData: begin
                if (tick_q == TickLast) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};
                    if (bit_q == BitLast) begin
                        state_d = StParity;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            StParity: begin
                if (tick_q == TickLast) begin
                    tick_d  = '0;
                    par_d   = rx_s;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick_q == TickLast) begin
                    tick_d  = '0;
                    frame_d = shift_q;
                    perr_d  = parity_bad;
                    ferr_d  = !rx_s;
                    valid_d = !parity_bad && rx_s;
                    ready_d = 1'b1;
                    // A low stop bit means the line may be held low; wait it out once.
                    state_d = rx_s ? StIdle : StBreak;
                end
            end
            StBreak: begin
                tick_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            frame_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign Frame     = frame_q;
    assign Valid     = valid_q;
    assign Ready     = ready_q;
    assign ParityErr = perr_q;
    assign FrameErr  = ferr_q;
    assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_frame_rx_oversampled.sv
// Self-checking bench for frame_rx_oversampled: directed vector table, randomized frames
// against a parity/stop reference model, and hand-written multi-cycle corner cases.
module tb_frame_rx_oversampled;

    localparam int unsigned B    = 16;
    localparam int unsigned W    = 10;
    localparam bit          PODD = 1'b0;
    // Edge offset from the Rx drop (cycle count at drive time) to the Ready observation.
    localparam int unsigned RdyLat = 3 + B / 2 + (W + 2) * B;

    logic         CLK = 1'b0;
    logic         RST_n;
    logic         Rx;
    logic [W-1:0] Frame;
    logic         Valid;
    logic         Ready;
    logic         ParityErr;
    logic         FrameErr;
    logic         Busy;

    frame_rx_oversampled #(
        .BIT_TICKS (B),
        .DATA_W    (W),
        .PARITY_ODD(PODD)
    ) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .Rx       (Rx),
        .Frame    (Frame),
        .Valid    (Valid),
        .Ready    (Ready),
        .ParityErr(ParityErr),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Log every Ready cycle with the outputs seen alongside it.
    int unsigned  rdy_cyc[$];
    logic [W-1:0] rdy_frame[$];
    logic         rdy_valid[$];
    always @(negedge CLK) begin
        if (Ready === 1'b1) begin
            rdy_cyc.push_back(cyc);
            rdy_frame.push_back(Frame);
            rdy_valid.push_back(Valid);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Hold one line level for a full bit time; starts and ends 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        Rx = b;
        repeat (B) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic pbit, input logic stop,
                              output int unsigned t_start);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(stop);
    endtask

    // Receiver-side view: data plus parity must hold an even (or odd) count of ones.
    function automatic void model(input logic [W-1:0] d, input logic pbit, input logic stop,
                                  output logic v, output logic pe, output logic fe);
        int ones;
        ones = $countones(d) + int'(pbit);
        pe   = ((ones % 2) == 1) != PODD;
        fe   = !stop;
        v    = !pe && !fe;
    endfunction

    function automatic logic good_pbit(input logic [W-1:0] d);
        return (($countones(d) % 2) == 1) ^ PODD;
    endfunction

    task automatic check_frame(input string name, input int unsigned t_start, input int nbefore,
                               input logic [W-1:0] ef, input logic ev, input logic epe,
                               input logic efe);
        check({name, " ready count"}, rdy_cyc.size(), nbefore + 1);
        if (rdy_cyc.size() > nbefore)
            check({name, " ready time"}, rdy_cyc[nbefore], t_start + RdyLat);
        check({name, " Frame"}, Frame, ef);
        check({name, " Valid"}, Valid, ev);
        check({name, " ParityErr"}, ParityErr, epe);
        check({name, " FrameErr"}, FrameErr, efe);
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic         pbit;
        logic         stop;
        logic         v;
        logic         pe;
        logic         fe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned t, t2, e;
        int          n;
        logic [W-1:0] d, f_prev;
        logic        pb, st, ev, epe, efe, v_prev;

        vecs[0] = '{10'h2A5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{10'h3FF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{10'h001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{10'h3FE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{10'h0F0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{10'h200, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state.
        RST_n = 1'b0;
        Rx    = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset Frame", Frame, 0);
        check("reset Valid", Valid, 0);
        check("reset Ready", Ready, 0);
        check("reset ParityErr", ParityErr, 0);
        check("reset FrameErr", FrameErr, 0);
        check("reset Busy", Busy, 0);
        RST_n = 1'b1;
        drive_bit(1'b1);
        check("idle Busy", Busy, 0);

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            n = rdy_cyc.size();
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stop, t);
            check_frame($sformatf("vec%0d", i), t, n, vecs[i].data, vecs[i].v, vecs[i].pe,
                        vecs[i].fe);
            drive_bit(1'b1);
            check($sformatf("vec%0d Busy after", i), Busy, 0);
        end

        // Randomized frames against the reference model.
        for (int i = 0; i < 24; i++) begin
            d  = W'($urandom);
            pb = ($urandom_range(0, 3) == 0) ? !good_pbit(d) : good_pbit(d);
            st = ($urandom_range(0, 7) != 0);
            model(d, pb, st, ev, epe, efe);
            n = rdy_cyc.size();
            send_frame(d, pb, st, t);
            check_frame($sformatf("rand%0d", i), t, n, d, ev, epe, efe);
            drive_bit(1'b1);
        end

        // Stop bit low, then line held low: exactly one errored frame.
        n = rdy_cyc.size();
        send_frame(10'h001, 1'b1, 1'b0, t);
        repeat (40 * B) @(posedge CLK);
        #1;
        check_frame("break", t, n, 10'h001, 1'b0, 1'b0, 1'b1);
        check("break Busy held", Busy, 1);
        Rx = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check("break Busy released", Busy, 0);
        check("break single ready", rdy_cyc.size(), n + 1);

        // Good frame, then a 5-cycle glitch must leave it untouched.
        n = rdy_cyc.size();
        send_frame(10'h0F0, 1'b0, 1'b1, t);
        check_frame("pre-glitch", t, n, 10'h0F0, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1);
        f_prev = Frame;
        v_prev = Valid;
        n      = rdy_cyc.size();
        e      = cyc;
        Rx     = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("glitch Busy rises", Busy, 1);
        repeat (2) @(posedge CLK);
        #1;
        Rx = 1'b1;
        repeat (7) @(posedge CLK);
        #1;
        check("glitch cycle", cyc, e + 12);
        check("glitch Busy cleared", Busy, 0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("glitch no ready", rdy_cyc.size(), n);
        check("glitch Frame kept", Frame, f_prev);
        check("glitch Valid kept", Valid, v_prev);

        // Back-to-back frames with no idle gap.
        n = rdy_cyc.size();
        send_frame(10'h155, good_pbit(10'h155), 1'b1, t);
        send_frame(10'h0AA, good_pbit(10'h0AA), 1'b1, t2);
        check("b2b ready count", rdy_cyc.size(), n + 2);
        if (rdy_cyc.size() >= n + 2) begin
            check("b2b first time", rdy_cyc[n], t + RdyLat);
            check("b2b spacing", rdy_cyc[n+1] - rdy_cyc[n], 13 * B);
            check("b2b first Frame", rdy_frame[n], 10'h155);
            check("b2b second Frame", rdy_frame[n+1], 10'h0AA);
            check("b2b first Valid", rdy_valid[n], 1);
            check("b2b second Valid", rdy_valid[n+1], 1);
        end
        drive_bit(1'b1);

        // Reset during data bit 4, then a clean frame.
        d = 10'h3C3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        Rx = d[4];
        repeat (B / 2) @(posedge CLK);
        #1;
        RST_n = 1'b0;
        #1;
        check("midreset Frame", Frame, 0);
        check("midreset Valid", Valid, 0);
        check("midreset Ready", Ready, 0);
        check("midreset ParityErr", ParityErr, 0);
        check("midreset FrameErr", FrameErr, 0);
        check("midreset Busy", Busy, 0);
        repeat (3) @(posedge CLK);
        #1;
        RST_n = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        n = rdy_cyc.size();
        send_frame(10'h12C, good_pbit(10'h12C), 1'b1, t);
        check_frame("post-reset", t, n, 10'h12C, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
